// File: rtl/alu_cmd_sequencer_pkg.sv
// Shared constants and FSM state type for the ALU command sequencer.
// The optional checksum feature is controlled by ALU_CMD_CHECKSUM_EN.
package alu_cmd_pkg;
    localparam logic [7:0] SYNC_CMD = 8'hA5;
    localparam logic [7:0] SYNC_RSP = 8'h5A;

    localparam int ST_ERR  = 7;
    localparam int ST_ILL  = 6;
    localparam int ST_CHK  = 5;
    localparam int ST_DIV0 = 4;

    localparam logic [3:0] OP_DIV     = 4'd10;
    localparam logic [3:0] OP_ILLEGAL = 4'd11;

    typedef enum logic [3:0] {
        IDLE,
        OPC,
        OPA,
        OPB,
        CHK,
        EXEC,
        RSP_HDR,
        RSP_RES,
        RSP_STAT,
        RSP_CHK
    } state_t;
endpackage

// File: rtl/alu_rsp_serializer.sv
// Response frame serializer: loads {hdr, result, status[, chk]} and shifts it out
// MSB-first under a valid/ready handshake. Checksum byte with ALU_CMD_CHECKSUM_EN.
module alu_rsp_serializer
    import alu_cmd_pkg::*;
#(
    parameter int N = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [N-1:0] result,
    input  logic [7:0]   status,
    input  logic         tx_ready,
    output logic [7:0]   tx_data,
    output logic         tx_valid,
    output logic         hs,
    output logic         stat_next
);
    localparam int NB = N / 8;
`ifdef ALU_CMD_CHECKSUM_EN
    localparam int CK = 1;
`else
    localparam int CK = 0;
`endif
    localparam int TOT = NB + 2 + CK;
    localparam int CW  = $clog2(TOT + 1);

    logic [8*TOT-1:0] frame_q;
    logic [CW-1:0]    left_q;

`ifdef ALU_CMD_CHECKSUM_EN
    logic [7:0] rsp_chk;
    always_comb begin
        rsp_chk = SYNC_RSP ^ status;
        for (int i = 0; i < NB; i++) begin
            rsp_chk = rsp_chk ^ result[8*i +: 8];
        end
    end
`endif

    assign tx_data   = frame_q[8*TOT-1 -: 8];
    assign tx_valid  = (left_q != '0);
    assign hs        = tx_valid && tx_ready;
    // Fires on the handshake of the last result byte, i.e. status is next.
    assign stat_next = hs && (left_q == CW'(CK + 2));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frame_q <= '0;
            left_q  <= '0;
        end else if (load) begin
`ifdef ALU_CMD_CHECKSUM_EN
            frame_q <= {SYNC_RSP, result, status, rsp_chk};
`else
            frame_q <= {SYNC_RSP, result, status};
`endif
            left_q  <= CW'(TOT);
        end else if (hs) begin
            frame_q <= frame_q << 8;
            left_q  <= left_q - 1'b1;
        end
    end
endmodule

// File: rtl/alu_cmd_sequencer.sv
// UART byte-stream front end for the ALU: parses command frames, screens errors,
// and returns a response frame. Trailing checksum bytes with ALU_CMD_CHECKSUM_EN.
module alu_cmd_sequencer
    import alu_cmd_pkg::*;
#(
    parameter int N           = 16,
    parameter int TIMEOUT_CYC = 100000
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [7:0]   rx_data,
    input  logic         rx_valid,
    output logic [7:0]   tx_data,
    output logic         tx_valid,
    input  logic         tx_ready,
    output logic [N-1:0] alu_a,
    output logic [N-1:0] alu_b,
    output logic [3:0]   alu_opcode,
    input  logic [N-1:0] alu_result,
    input  logic [3:0]   alu_flags,
    output logic         busy,
    output logic         overrun
);
    localparam int NB = N / 8;
    localparam int BW = $clog2(NB + 1);
    localparam int TW = $clog2(TIMEOUT_CYC + 1);

    state_t        state, next;
    logic [BW-1:0] bcnt;
    logic [TW-1:0] tcnt;
    logic          in_cmd, in_rsp, byte_last, timeout;
    logic          hs, stat_next, load;
    logic [N-1:0]  exec_res;
    logic [7:0]    exec_stat;
`ifdef ALU_CMD_CHECKSUM_EN
    logic [7:0]    xacc;
    logic          chk_ok;
`endif

    function automatic logic [N-1:0] shift_in(input logic [N-1:0] v, input logic [7:0] b);
        logic [N+7:0] t;
        t = {v, b};
        return t[N-1:0];
    endfunction

    assign in_cmd    = state inside {OPC, OPA, OPB, CHK};
    assign in_rsp    = state inside {EXEC, RSP_HDR, RSP_RES, RSP_STAT, RSP_CHK};
    assign byte_last = (bcnt == BW'(NB - 1));
    assign timeout   = in_cmd && !rx_valid && (tcnt == TW'(TIMEOUT_CYC - 1));
    assign busy      = (state != IDLE);
    assign load      = (state == EXEC);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= next;
    end

    always_comb begin
        next = state;
        case (state)
            IDLE:     if (rx_valid && rx_data == SYNC_CMD) next = OPC;
            OPC:      if (rx_valid) next = OPA;
            OPA:      if (rx_valid && byte_last) next = OPB;
`ifdef ALU_CMD_CHECKSUM_EN
            OPB:      if (rx_valid && byte_last) next = CHK;
`else
            OPB:      if (rx_valid && byte_last) next = EXEC;
`endif
            CHK:      if (rx_valid) next = EXEC;
            EXEC:     next = RSP_HDR;
            RSP_HDR:  if (hs) next = RSP_RES;
            RSP_RES:  if (stat_next) next = RSP_STAT;
`ifdef ALU_CMD_CHECKSUM_EN
            RSP_STAT: if (hs) next = RSP_CHK;
`else
            RSP_STAT: if (hs) next = IDLE;
`endif
            RSP_CHK:  if (hs) next = IDLE;
            default:  next = IDLE;
        endcase
        if (timeout) next = IDLE;
    end

    // Error screening; checksum mismatch is applied last so it wins.
    always_comb begin
        exec_res  = alu_result;
        exec_stat = {4'b0, alu_flags};
        if (alu_opcode == OP_ILLEGAL) begin
            exec_res  = '0;
            exec_stat = 8'h00;
            exec_stat[ST_ERR] = 1'b1;
            exec_stat[ST_ILL] = 1'b1;
        end else if (alu_opcode == OP_DIV && alu_b == '0) begin
            exec_res  = '0;
            exec_stat = 8'h00;
            exec_stat[ST_ERR]  = 1'b1;
            exec_stat[ST_DIV0] = 1'b1;
        end
`ifdef ALU_CMD_CHECKSUM_EN
        if (!chk_ok) begin
            exec_res  = '0;
            exec_stat = 8'h00;
            exec_stat[ST_ERR] = 1'b1;
            exec_stat[ST_CHK] = 1'b1;
        end
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            alu_a      <= '0;
            alu_b      <= '0;
            alu_opcode <= '0;
            bcnt       <= '0;
            tcnt       <= '0;
            overrun    <= 1'b0;
`ifdef ALU_CMD_CHECKSUM_EN
            xacc       <= '0;
            chk_ok     <= 1'b1;
`endif
        end else begin
            overrun <= rx_valid && in_rsp;
            if (!in_cmd || rx_valid) tcnt <= '0;
            else                     tcnt <= tcnt + 1'b1;
            if (rx_valid) begin
                case (state)
                    IDLE: if (rx_data == SYNC_CMD) begin
                        bcnt <= '0;
`ifdef ALU_CMD_CHECKSUM_EN
                        xacc   <= SYNC_CMD;
                        chk_ok <= 1'b1;
`endif
                    end
                    OPC: begin
                        alu_opcode <= rx_data[3:0];
`ifdef ALU_CMD_CHECKSUM_EN
                        xacc <= xacc ^ rx_data;
`endif
                    end
                    OPA, OPB: begin
                        if (state == OPA) alu_a <= shift_in(alu_a, rx_data);
                        else              alu_b <= shift_in(alu_b, rx_data);
                        bcnt <= byte_last ? '0 : bcnt + 1'b1;
`ifdef ALU_CMD_CHECKSUM_EN
                        xacc <= xacc ^ rx_data;
`endif
                    end
`ifdef ALU_CMD_CHECKSUM_EN
                    CHK: chk_ok <= (rx_data == xacc);
`endif
                    default: ;
                endcase
            end
        end
    end

    alu_rsp_serializer #(.N(N)) u_ser (
        .clk       (clk),
        .rst       (rst),
        .load      (load),
        .result    (exec_res),
        .status    (exec_stat),
        .tx_ready  (tx_ready),
        .tx_data   (tx_data),
        .tx_valid  (tx_valid),
        .hs        (hs),
        .stat_next (stat_next)
    );
endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Table-driven, scoreboarded bench for alu_cmd_sequencer (N=16, TIMEOUT_CYC=16).
// Builds with or without ALU_CMD_CHECKSUM_EN.
module tb_alu_cmd_sequencer;
`ifdef ALU_CMD_CHECKSUM_EN
    localparam bit CK_EN = 1'b1;
`else
    localparam bit CK_EN = 1'b0;
`endif
    localparam int NBYTES = 4 + int'(CK_EN);

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic [15:0] alu_a, alu_b, alu_result;
    logic [3:0]  alu_opcode, alu_flags;
    logic        busy, overrun;

    alu_cmd_sequencer #(.N(16), .TIMEOUT_CYC(16)) dut (
        .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .alu_a(alu_a), .alu_b(alu_b), .alu_opcode(alu_opcode),
        .alu_result(alu_result), .alu_flags(alu_flags),
        .busy(busy), .overrun(overrun)
    );

    always #5 clk = ~clk;

    // Stand-in ALU core; div-by-zero and illegal opcodes give junk the DUT must hide.
    logic v_ovf;
    always_comb begin
        case (alu_opcode)
            4'd0:    alu_result = alu_a & alu_b;
            4'd1:    alu_result = alu_a | alu_b;
            4'd2:    alu_result = alu_a ^ alu_b;
            4'd3:    alu_result = alu_a + alu_b;
            4'd10:   alu_result = (alu_b != 0) ? alu_a / alu_b : 16'hDEAD;
            default: alu_result = 16'hBEEF;
        endcase
        v_ovf = (alu_opcode == 4'd3) && (alu_a[15] == alu_b[15]) && (alu_result[15] != alu_a[15]);
        if ((alu_opcode == 4'd10 && alu_b == 0) || alu_opcode == 4'd11) alu_flags = 4'hF;
        else alu_flags = {v_ovf, alu_result[15], alu_result == 16'h0, ~^alu_result};
    end

    typedef struct {
        logic [7:0]  opc;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] res;
        logic [7:0]  stat;
    } vec_t;

    vec_t       tbl[8];
    logic [7:0] sb[$];
    int         vectors = 0;
    int         miscompares = 0;
    logic       hold_chk = 1'b0;
    logic [7:0] hold_data = 8'h00;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    // Response monitor: every handshake pops the scoreboard; stalled bytes must hold.
    always @(negedge clk) begin
        if (rst) begin
            hold_chk = 1'b0;
        end else begin
            if (hold_chk) begin
                vectors++;
                if (!tx_valid || tx_data !== hold_data) begin
                    miscompares++;
                    $display("FAIL hold: got valid=%0b data=%0h, expected valid=1 data=%0h",
                             tx_valid, tx_data, hold_data);
                end
            end
            if (tx_valid && tx_ready) begin
                vectors++;
                if (sb.size() == 0) begin
                    miscompares++;
                    $display("FAIL unexpected_tx: got %0h, expected no byte", tx_data);
                end else begin
                    logic [7:0] e;
                    e = sb.pop_front();
                    if (tx_data !== e) begin
                        miscompares++;
                        $display("FAIL rsp_byte: got %0h, expected %0h", tx_data, e);
                    end
                end
            end
            hold_chk  = tx_valid && !tx_ready;
            hold_data = tx_data;
        end
    end

    task automatic send_byte(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
    endtask

    task automatic send_frame(input vec_t v, input bit bad);
        logic [7:0] x;
        x = 8'hA5 ^ v.opc ^ v.a[15:8] ^ v.a[7:0] ^ v.b[15:8] ^ v.b[7:0] ^ {7'b0, bad};
        send_byte(8'hA5);
        send_byte(v.opc);
        send_byte(v.a[15:8]);
        send_byte(v.a[7:0]);
        send_byte(v.b[15:8]);
        send_byte(v.b[7:0]);
        if (CK_EN) send_byte(x);
    endtask

    task automatic expect_rsp(input logic [15:0] res, input logic [7:0] stat);
        sb.push_back(8'h5A);
        sb.push_back(res[15:8]);
        sb.push_back(res[7:0]);
        sb.push_back(stat);
        if (CK_EN) sb.push_back(8'h5A ^ res[15:8] ^ res[7:0] ^ stat);
    endtask

    task automatic wait_done();
        int n = 0;
        while ((sb.size() != 0 || busy) && n < 200) begin
            @(negedge clk);
            n++;
        end
        vectors++;
        if (n >= 200) begin
            miscompares++;
            $display("FAIL drain: got %0d bytes pending busy=%0b, expected 0 and 0", sb.size(), busy);
            sb.delete();
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: got no finish, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0] = '{8'h00, 16'hAAAA, 16'h5555, 16'h0000, 8'h03};
        tbl[1] = '{8'h01, 16'h1200, 16'h0034, 16'h1234, 8'h00};
        tbl[2] = '{8'h03, 16'h7FFF, 16'h0001, 16'h8000, 8'h0C};
        tbl[3] = '{8'h0A, 16'h0064, 16'h0000, 16'h0000, 8'h90};
        tbl[4] = '{8'h0A, 16'h0064, 16'h0005, 16'h0014, 8'h01};
        tbl[5] = '{8'hFB, 16'h1234, 16'h5678, 16'h0000, 8'hC0};
        tbl[6] = '{8'h32, 16'hFF00, 16'h0FF0, 16'hF0F0, 8'h05};
        tbl[7] = '{8'h03, 16'hFFFF, 16'h0001, 16'h0000, 8'h03};

        rst = 1'b1; rx_valid = 1'b0; rx_data = 8'h00; tx_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_tx_valid", tx_valid, 0);
        check("rst_tx_data", tx_data, 0);
        check("rst_alu_a", alu_a, 0);
        check("rst_alu_b", alu_b, 0);
        check("rst_opcode", alu_opcode, 0);
        check("rst_busy", busy, 0);
        check("rst_overrun", overrun, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        // AND frame with latency: EXEC at t+1, header at t+2.
        tx_ready = 1'b0;
        expect_rsp(tbl[0].res, tbl[0].stat);
        send_frame(tbl[0], 1'b0);
        @(negedge clk);
        check("exec_no_valid", tx_valid, 0);
        check("exec_busy", busy, 1);
        @(negedge clk);
        check("lat_valid", tx_valid, 1);
        check("lat_hdr", tx_data, 8'h5A);
        @(posedge clk); #1;
        tx_ready = 1'b1;
        wait_done();

        for (int i = 1; i < 8; i++) begin
            expect_rsp(tbl[i].res, tbl[i].stat);
            send_frame(tbl[i], 1'b0);
            wait_done();
        end

`ifdef ALU_CMD_CHECKSUM_EN
        expect_rsp(16'h0000, 8'hA0);
        send_frame(tbl[3], 1'b1);
        wait_done();
`endif

        // Garbage before sync is ignored.
        send_byte(8'h12);
        send_byte(8'h34);
        expect_rsp(tbl[1].res, tbl[1].stat);
        send_frame(tbl[1], 1'b0);
        wait_done();

        // Byte during response: one overrun pulse, response intact.
        expect_rsp(tbl[2].res, tbl[2].stat);
        send_frame(tbl[2], 1'b0);
        @(posedge clk); #1;
        send_byte(8'hA5);
        @(negedge clk);
        check("overrun_pulse", overrun, 1);
        @(negedge clk);
        check("overrun_clear", overrun, 0);
        @(posedge clk); #1;
        wait_done();

        // Backpressure: tx_ready low 5 cycles per byte.
        tx_ready = 1'b0;
        expect_rsp(tbl[3].res, tbl[3].stat);
        send_frame(tbl[3], 1'b0);
        @(posedge clk); #1;
        for (int k = 0; k < NBYTES; k++) begin
            repeat (5) @(posedge clk);
            #1;
            tx_ready = 1'b1;
            @(posedge clk); #1;
            tx_ready = 1'b0;
        end
        tx_ready = 1'b1;
        wait_done();
        check("bp_busy_low", busy, 0);

        // Timeout after A_hi: back to IDLE with no response.
        send_byte(8'hA5);
        @(negedge clk);
        check("busy_rise", busy, 1);
        @(posedge clk); #1;
        send_byte(8'h00);
        send_byte(8'hAA);
        repeat (25) @(posedge clk);
        #1;
        @(negedge clk);
        check("timeout_idle", busy, 0);
        check("timeout_no_tx", tx_valid, 0);
        @(posedge clk); #1;
        expect_rsp(tbl[4].res, tbl[4].stat);
        send_frame(tbl[4], 1'b0);
        wait_done();

        // Reset during the response abandons it.
        tx_ready = 1'b0;
        send_frame(tbl[5], 1'b0);
        @(posedge clk);
        #2;
        check("pre_rst_valid", tx_valid, 1);
        rst = 1'b1;
        #1;
        check("mid_rst_tx_valid", tx_valid, 0);
        check("mid_rst_tx_data", tx_data, 0);
        check("mid_rst_alu_a", alu_a, 0);
        check("mid_rst_alu_b", alu_b, 0);
        check("mid_rst_opcode", alu_opcode, 0);
        check("mid_rst_busy", busy, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        tx_ready = 1'b1;
        @(posedge clk); #1;
        expect_rsp(tbl[6].res, tbl[6].stat);
        send_frame(tbl[6], 1'b0);
        wait_done();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
